// File: rtl/ysyx_25010008_xbar_pkg.sv
// ysyx_25010008_xbar_pkg: shared types and constants for the crossbar.
// Rev 1.0 -- states, target select, CLINT window, AXI response codes.
`default_nettype none

package ysyx_25010008_xbar_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      R_REQ  = 3'd1,
      R_WAIT = 3'd2,
      R_RESP = 3'd3,
      W_REQ  = 3'd4,
      W_WAIT = 3'd5,
      W_RESP = 3'd6
   } xbar_state_t;

   typedef enum logic [1:0] {
      TGT_CLINT = 2'd0,
      TGT_SOC   = 2'd1,
      TGT_ERR   = 2'd2
   } xbar_tgt_t;

   localparam logic [15:0] CLINT_REGION = 16'h0200;
   localparam logic [31:0] CLINT_BASE   = 32'h0200_0048;
   localparam logic [31:0] CLINT_LIMIT  = 32'h0200_004F;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

`default_nettype wire

// File: rtl/ysyx_25010008_xbar_decode.sv
// ysyx_25010008_xbar_decode: maps an address and access direction to a target.
// Rev 1.0
`default_nettype none

module ysyx_25010008_xbar_decode
   import ysyx_25010008_xbar_pkg::*;
(
   input  logic [31:0] i_addr,
   input  logic        i_is_write,
   output xbar_tgt_t   o_tgt
);

   // The whole 0x0200_xxxx page belongs to the CLINT; only mtime is mapped, read-only.
   always_comb begin
      o_tgt = TGT_SOC;
      if (i_addr[31:16] == CLINT_REGION) begin
         if (!i_is_write && (i_addr >= CLINT_BASE) && (i_addr <= CLINT_LIMIT))
            o_tgt = TGT_CLINT;
         else
            o_tgt = TGT_ERR;
      end
   end

endmodule

`default_nettype wire

// File: rtl/ysyx_25010008_xbar.sv
// ysyx_25010008_xbar: single-outstanding AXI4-Lite crossbar, upstream -> CLINT / SoC.
// Rev 1.0 -- optional target timeout and dead-target marking under XBAR_TIMEOUT_EN.
`default_nettype none

module ysyx_25010008_xbar
   import ysyx_25010008_xbar_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] u_araddr,
   input  logic        u_arvalid,
   output logic        u_arready,
   output logic [31:0] u_rdata,
   output logic [1:0]  u_rresp,
   output logic        u_rvalid,
   input  logic        u_rready,
   input  logic [31:0] u_awaddr,
   input  logic        u_awvalid,
   output logic        u_awready,
   input  logic [31:0] u_wdata,
   input  logic [3:0]  u_wstrb,
   input  logic        u_wvalid,
   output logic        u_wready,
   output logic [1:0]  u_bresp,
   output logic        u_bvalid,
   input  logic        u_bready,
   output logic [31:0] c_araddr,
   output logic        c_arvalid,
   input  logic        c_arready,
   input  logic [31:0] c_rdata,
   input  logic [1:0]  c_rresp,
   input  logic        c_rvalid,
   output logic        c_rready,
   output logic [31:0] s_araddr,
   output logic        s_arvalid,
   input  logic        s_arready,
   input  logic [31:0] s_rdata,
   input  logic [1:0]  s_rresp,
   input  logic        s_rvalid,
   output logic        s_rready,
   output logic [31:0] s_awaddr,
   output logic        s_awvalid,
   input  logic        s_awready,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrb,
   output logic        s_wvalid,
   input  logic        s_wready,
   input  logic [1:0]  s_bresp,
   input  logic        s_bvalid,
   output logic        s_bready
);

   if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES out of range 1..65535");
   end

   xbar_state_t r_state, w_next;
   xbar_tgt_t   r_tgt, w_dec_tgt;
   logic [31:0] r_addr, r_wdata, r_rdata;
   logic [3:0]  r_wstrb;
   logic [1:0]  r_resp;
   logic        r_aw_done, r_w_done;
   logic        w_rd_acc, w_wr_acc, w_r_cap, w_b_cap, w_aw_hs, w_w_hs;
   logic        w_to, w_dead, w_skip;

   // One decoder serves both channels; a pending read always has priority.
   ysyx_25010008_xbar_decode u_decode (
      .i_addr     (u_arvalid ? u_araddr : u_awaddr),
      .i_is_write (!u_arvalid),
      .o_tgt      (w_dec_tgt)
   );

`ifdef XBAR_TIMEOUT_EN
   logic [15:0] r_cnt;
   logic        r_dead_clint, r_dead_soc;
   logic        w_busy;

   assign w_busy = (r_state == R_REQ) || (r_state == R_WAIT) ||
                   (r_state == W_REQ) || (r_state == W_WAIT);
   assign w_to   = w_busy && (r_cnt == 16'(TIMEOUT_CYCLES));
   assign w_dead = ((w_dec_tgt == TGT_CLINT) && r_dead_clint) ||
                   ((w_dec_tgt == TGT_SOC)   && r_dead_soc);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_cnt        <= '0;
         r_dead_clint <= 1'b0;
         r_dead_soc   <= 1'b0;
      end else begin
         if (w_rd_acc || w_wr_acc)
            r_cnt <= '0;
         else if (w_busy)
            r_cnt <= r_cnt + 16'd1;
         if (w_to && (r_tgt == TGT_CLINT))
            r_dead_clint <= 1'b1;
         if (w_to && (r_tgt == TGT_SOC))
            r_dead_soc <= 1'b1;
      end
   end
`else
   assign w_to   = 1'b0;
   assign w_dead = 1'b0;
`endif

   assign w_skip = (w_dec_tgt == TGT_ERR) || w_dead;

   always_comb begin
      w_next    = r_state;
      u_arready = 1'b0;
      u_awready = 1'b0;
      u_wready  = 1'b0;
      u_rvalid  = 1'b0;
      u_bvalid  = 1'b0;
      c_arvalid = 1'b0;
      c_rready  = 1'b0;
      s_arvalid = 1'b0;
      s_rready  = 1'b0;
      s_awvalid = 1'b0;
      s_wvalid  = 1'b0;
      s_bready  = 1'b0;
      w_rd_acc  = 1'b0;
      w_wr_acc  = 1'b0;
      w_r_cap   = 1'b0;
      w_b_cap   = 1'b0;
      w_aw_hs   = 1'b0;
      w_w_hs    = 1'b0;
      case (r_state)
         IDLE: begin
            u_arready = !reset;
            u_awready = !reset && u_awvalid && u_wvalid && !u_arvalid;
            u_wready  = u_awready;
            w_rd_acc  = u_arready && u_arvalid;
            w_wr_acc  = u_awready;
            if (w_rd_acc)
               w_next = w_skip ? R_RESP : R_REQ;
            else if (w_wr_acc)
               w_next = w_skip ? W_RESP : W_REQ;
         end
         R_REQ: begin
            if (w_to) begin
               w_next = R_RESP;
            end else if (r_tgt == TGT_CLINT) begin
               c_arvalid = 1'b1;
               if (c_arready) w_next = R_WAIT;
            end else begin
               s_arvalid = 1'b1;
               if (s_arready) w_next = R_WAIT;
            end
         end
         R_WAIT: begin
            if (w_to) begin
               w_next = R_RESP;
            end else begin
               c_rready = (r_tgt == TGT_CLINT);
               s_rready = (r_tgt == TGT_SOC);
               w_r_cap  = (c_rready && c_rvalid) || (s_rready && s_rvalid);
               if (w_r_cap) w_next = R_RESP;
            end
         end
         R_RESP: begin
            u_rvalid = 1'b1;
            if (u_rready) w_next = IDLE;
         end
         W_REQ: begin
            if (w_to) begin
               w_next = W_RESP;
            end else begin
               s_awvalid = !r_aw_done;
               s_wvalid  = !r_w_done;
               w_aw_hs   = s_awvalid && s_awready;
               w_w_hs    = s_wvalid && s_wready;
               if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_next = W_WAIT;
            end
         end
         W_WAIT: begin
            if (w_to) begin
               w_next = W_RESP;
            end else begin
               s_bready = 1'b1;
               w_b_cap  = s_bvalid;
               if (w_b_cap) w_next = W_RESP;
            end
         end
         W_RESP: begin
            u_bvalid = 1'b1;
            if (u_bready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   assign c_araddr = c_arvalid ? r_addr  : '0;
   assign s_araddr = s_arvalid ? r_addr  : '0;
   assign s_awaddr = s_awvalid ? r_addr  : '0;
   assign s_wdata  = s_wvalid  ? r_wdata : '0;
   assign s_wstrb  = s_wvalid  ? r_wstrb : '0;
   assign u_rdata  = r_rdata;
   assign u_rresp  = r_resp;
   assign u_bresp  = r_resp;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_tgt     <= TGT_CLINT;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_rdata   <= '0;
         r_resp    <= RESP_OKAY;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_rd_acc || w_wr_acc) begin
            r_addr    <= w_rd_acc ? u_araddr : u_awaddr;
            r_tgt     <= w_dec_tgt;
            r_rdata   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_resp    <= !w_skip ? RESP_OKAY :
                         ((w_dec_tgt == TGT_ERR) ? RESP_DECERR : RESP_SLVERR);
         end
         if (w_wr_acc) begin
            r_wdata <= u_wdata;
            r_wstrb <= u_wstrb;
         end
         if (w_aw_hs) r_aw_done <= 1'b1;
         if (w_w_hs)  r_w_done  <= 1'b1;
         if (w_r_cap) begin
            r_rdata <= (r_tgt == TGT_CLINT) ? c_rdata : s_rdata;
            r_resp  <= (r_tgt == TGT_CLINT) ? c_rresp : s_rresp;
         end
         if (w_b_cap) r_resp <= s_bresp;
         if (w_to) begin
            r_rdata <= '0;
            r_resp  <= RESP_SLVERR;
         end
      end
   end

endmodule

`default_nettype wire
